// File: rtl/uart_periph_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, CON bit layout, FSM states.
package uart_periph_pkg;

  // Register offsets from the peripheral base address
  localparam logic [31:0] OFF_TXD = 32'h0000_0000;
  localparam logic [31:0] OFF_RXD = 32'h0000_0004;
  localparam logic [31:0] OFF_CON = 32'h0000_0008;

  // CON register bit positions
  localparam int unsigned CON_TX_IRQ_EN  = 0;
  localparam int unsigned CON_RX_IRQ_EN  = 1;
  localparam int unsigned CON_TX_DONE    = 2;
  localparam int unsigned CON_RX_VALID   = 3;
  localparam int unsigned CON_TX_BUSY    = 4;
  localparam int unsigned CON_RX_OVERRUN = 5;
  localparam int unsigned CON_FRAME_ERR  = 6;

  // Serial FSM states, shared by the TX and RX engines
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer plus mid-bit sampling FSM; emits one-cycle byte_ok / frame_bad pulses.
module uart_rx_core
  import uart_periph_pkg::*;
#(
  parameter int unsigned DIVISOR = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_bad
);

  localparam int unsigned CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR / 2 - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_ok_q, byte_ok_d;
  logic          frame_bad_q, frame_bad_d;

  assign rx_byte   = shift_q;
  assign byte_ok   = byte_ok_q;
  assign frame_bad = frame_bad_q;

  // Next-state: synchronizer shift, start validation at half bit, then one sample per bit period
  always_comb begin
    sync1_d     = rx_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_ok_d   = 1'b0;
    frame_bad_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid start bit is a glitch, not a frame
          state_d = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (sync2_q) begin
            byte_ok_d = 1'b1;
          end else begin
            frame_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset; synchronizer resets to line idle
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_ok_q   <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_ok_q   <= byte_ok_d;
      frame_bad_q <= frame_bad_d;
    end
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX FSM, level interrupt, combinational read data.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned DIVISOR = CLK_HZ / BAUD,
  parameter logic [31:0] BASE    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);

  localparam int unsigned CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [31:0] ADDR_TXD = BASE + OFF_TXD;
  localparam logic [31:0] ADDR_RXD = BASE + OFF_RXD;
  localparam logic [31:0] ADDR_CON = BASE + OFF_CON;

  // Word-address decode; byte offset bits are don't-care
  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_bus;

  assign hit_txd    = (addr[31:2] == ADDR_TXD[31:2]);
  assign hit_rxd    = (addr[31:2] == ADDR_RXD[31:2]);
  assign hit_con    = (addr[31:2] == ADDR_CON[31:2]);
  assign wr_txd     = wr & hit_txd;
  assign wr_con     = wr & hit_con;
  assign rd_rxd     = rd & hit_rxd;
  assign rd_con     = rd & hit_con;
  assign unused_bus = ^{addr[1:0], wdata[31:8]};

  // TX engine state
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_done_set;
  logic          tx_busy;

  // Register file state
  logic       tx_irq_en_q, tx_irq_en_d;
  logic       rx_irq_en_q, rx_irq_en_d;
  logic       tx_done_q, tx_done_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] rx_data_q, rx_data_d;

  // Receiver outputs
  logic [7:0] rx_byte;
  logic       rx_byte_ok;
  logic       rx_frame_bad;

  logic [31:0] con_word;

  uart_rx_core #(
    .DIVISOR (DIVISOR)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (uart_rx),
    .rx_byte   (rx_byte),
    .byte_ok   (rx_byte_ok),
    .frame_bad (rx_frame_bad)
  );

  assign tx_busy = (tx_state_q != ST_IDLE);
  assign uart_tx = tx_line_q;
  assign irqout  = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);

  // TX next-state: each of START/DATA/STOP lasts DIVISOR clocks, line value is registered
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_line_d   = tx_line_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      ST_IDLE: begin
        tx_line_d = 1'b1;
        if (wr_txd) begin
          tx_shift_d = wdata[7:0];
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
          tx_line_d  = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = ST_DATA;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d    = '0;
          tx_state_d  = ST_IDLE;
          tx_line_d   = 1'b1;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = '0;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // Register file next-state: sticky flags where a set in the same cycle wins over a read-clear
  always_comb begin
    tx_irq_en_d  = tx_irq_en_q;
    rx_irq_en_d  = rx_irq_en_q;
    if (wr_con) begin
      tx_irq_en_d = wdata[0];
      rx_irq_en_d = wdata[1];
    end
    tx_done_d    = tx_done_set | (tx_done_q & ~rd_con);
    rx_valid_d   = rx_byte_ok | (rx_valid_q & ~rd_rxd);
    // An RXD read in the completion cycle consumes the old byte, so it is not an overrun
    rx_overrun_d = (rx_byte_ok & rx_valid_q & ~rd_rxd) | (rx_overrun_q & ~rd_con);
    frame_err_d  = rx_frame_bad | (frame_err_q & ~rd_con);
    rx_data_d    = rx_byte_ok ? rx_byte : rx_data_q;
  end

  // Combinational read mux for the single-cycle load path
  always_comb begin
    con_word                 = '0;
    con_word[CON_TX_IRQ_EN]  = tx_irq_en_q;
    con_word[CON_RX_IRQ_EN]  = rx_irq_en_q;
    con_word[CON_TX_DONE]    = tx_done_q;
    con_word[CON_RX_VALID]   = rx_valid_q;
    con_word[CON_TX_BUSY]    = tx_busy;
    con_word[CON_RX_OVERRUN] = rx_overrun_q;
    con_word[CON_FRAME_ERR]  = frame_err_q;
    rdata = '0;
    if (rd) begin
      if (hit_rxd) begin
        rdata = {24'b0, rx_data_q};
      end else if (hit_con) begin
        rdata = con_word;
      end
    end
  end

  // State registers; reset aborts any frame and returns the line high next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_line_q    <= 1'b1;
      tx_irq_en_q  <= 1'b0;
      rx_irq_en_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_line_q    <= tx_line_d;
      tx_irq_en_q  <= tx_irq_en_d;
      rx_irq_en_q  <= rx_irq_en_d;
      tx_done_q    <= tx_done_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      frame_err_q  <= frame_err_d;
      rx_data_q    <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph with a bus-level register/flag model and a line-level frame model.
module tb_uart_periph;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset, rd, wr, uart_rx, uart_tx, irqout;
  logic [31:0] addr, wdata, rdata;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the programmer-visible state
  logic       m_tx_en, m_rx_en, m_tx_done, m_rx_valid, m_overrun, m_ferr, m_busy;
  logic [7:0] m_data;

  logic [31:0] d, exp_w;
  logic [7:0]  b, rb;
  logic        ok, saw_low;

  always #5 clk = ~clk;

  uart_periph #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irqout  (irqout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_con();
    return {25'b0, m_ferr, m_overrun, m_busy, m_rx_valid, m_tx_done, m_rx_en, m_tx_en};
  endfunction

  function automatic logic [31:0] exp_irq();
    return {31'b0, (m_tx_en & m_tx_done) | (m_rx_en & m_rx_valid)};
  endfunction

  task automatic model_reset();
    m_tx_en = 0; m_rx_en = 0; m_tx_done = 0; m_rx_valid = 0;
    m_overrun = 0; m_ferr = 0; m_busy = 0; m_data = 8'h00;
  endtask

  // Receiver rules: good stop delivers (overrun if unread), bad stop only flags
  task automatic model_rx(input logic [7:0] v, input logic stop);
    if (stop) begin
      if (m_rx_valid) m_overrun = 1;
      m_rx_valid = 1;
      m_data = v;
    end else begin
      m_ferr = 1;
    end
  endtask

  // Look at combinational read data without a clock edge (no side effects)
  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    rd = 1; addr = a; #1 v = rdata; rd = 0; addr = '0;
  endtask

  // Clocked read: data captured before the edge, read side effects applied to the model
  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    rd = 1; addr = a; #1 v = rdata;
    @(posedge clk); #1 rd = 0; addr = '0;
    if (a == A_CON) begin m_tx_done = 0; m_overrun = 0; m_ferr = 0; end
    if (a == A_RXD) m_rx_valid = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    wr = 1; addr = a; wdata = v;
    @(posedge clk); #1 wr = 0; addr = '0; wdata = '0;
    if (a == A_CON) begin m_tx_en = v[0]; m_rx_en = v[1]; end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    peek(A_CON, v);
    check({tag, "_con"}, v, exp_con());
    check({tag, "_irq"}, {31'b0, irqout}, exp_irq());
  endtask

  // Decode one frame from uart_tx by mid-bit sampling
  task automatic tx_monitor(input logic chk_busy, output logic [7:0] v, output logic good);
    int n = 0;
    logic [31:0] c;
    good = 1; v = '0;
    while (uart_tx !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    if (uart_tx !== 1'b0) begin good = 0; return; end
    repeat (7) @(posedge clk); #1;
    if (uart_tx !== 1'b0) good = 0;
    if (chk_busy) begin peek(A_CON, c); check("tx_busy_start", {31'b0, c[4]}, 1); end
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk); #1;
      v[i] = uart_tx;
      if (chk_busy) begin peek(A_CON, c); check("tx_busy_data", {31'b0, c[4]}, 1); end
    end
    repeat (16) @(posedge clk); #1;
    if (uart_tx !== 1'b1) good = 0;
  endtask

  // Drive one 8N1 frame on uart_rx, 16 clocks per bit
  task automatic send_frame(input logic [7:0] v, input logic stop);
    uart_rx = 0; repeat (16) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin uart_rx = v[i]; repeat (16) @(posedge clk); #1; end
    uart_rx = stop; repeat (16) @(posedge clk); #1;
    uart_rx = 1;
  endtask

  initial begin
    reset = 1; rd = 0; wr = 0; addr = '0; wdata = '0; uart_rx = 1;
    model_reset();
    repeat (3) @(posedge clk); #1 reset = 0;

    // Reset state and decode
    check("rst_tx", {31'b0, uart_tx}, 1);
    check_state("rst");
    peek(A_RXD, d); check("rst_rxd", d, 0);
    peek(A_TXD, d); check("rst_txd_read", d, 0);
    peek(A_CON + 32'd12, d); check("unmapped_read", d, 0);

    // TX frames: fixed A5 then random bytes, alternating tx_irq_en
    for (int k = 0; k < 3; k++) begin
      rb = (k == 0) ? 8'hA5 : 8'($urandom);
      bus_write(A_CON, {31'b0, 1'(k % 2)});
      bus_write(A_TXD, {24'b0, rb});
      m_busy = 1;
      tx_monitor(1'b1, b, ok);
      check("tx_frame_ok", {31'b0, ok}, 1);
      check("tx_byte", {24'b0, b}, {24'b0, rb});
      repeat (8) @(posedge clk); #1;
      check_state("tx_pre_done");
      @(posedge clk); #1;
      m_busy = 0; m_tx_done = 1;
      check_state("tx_done");
      exp_w = exp_con();
      bus_read(A_CON, d); check("tx_con_read", d, exp_w);
      check_state("tx_done_clr");
    end

    // Busy guard: second write 5 clocks later is dropped
    bus_write(A_CON, 32'h0);
    bus_write(A_TXD, 32'h3C);
    m_busy = 1;
    fork
      tx_monitor(1'b0, b, ok);
      begin repeat (4) @(posedge clk); #1 bus_write(A_TXD, 32'hFF); end
    join
    check("guard_frame_ok", {31'b0, ok}, 1);
    check("guard_byte", {24'b0, b}, 32'h3C);
    repeat (9) @(posedge clk); #1;
    m_busy = 0; m_tx_done = 1;
    check_state("guard_done");
    saw_low = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (uart_tx !== 1'b1) saw_low = 1; end
    check("guard_no_second", {31'b0, saw_low}, 0);
    bus_read(A_CON, d);

    // CON read in the exact cycle tx_done sets: pre-edge value returned, set wins
    bus_write(A_TXD, {24'b0, 8'($urandom)});
    m_busy = 1;
    tx_monitor(1'b0, b, ok);
    repeat (8) @(posedge clk); #1;
    exp_w = exp_con();
    bus_read(A_CON, d); check("simul_con_read", d, exp_w);
    m_busy = 0; m_tx_done = 1;
    check_state("simul_after");
    bus_read(A_CON, d);

    // RX path with rx_irq_en
    bus_write(A_CON, 32'h2);
    for (int k = 0; k < 4; k++) begin
      rb = (k == 0) ? 8'h5A : 8'($urandom);
      send_frame(rb, 1'b1);
      model_rx(rb, 1'b1);
      check_state("rx_got");
      if (k == 0) begin
        rd = 0; addr = A_CON; #1 check("rd_low_zero", rdata, 0); addr = '0;
      end
      bus_read(A_RXD, d); check("rx_rxd_read", d, {24'b0, rb});
      check_state("rx_cleared");
    end

    // Glitch shorter than half a bit: no state change
    uart_rx = 0; repeat (4) @(posedge clk); #1 uart_rx = 1;
    repeat (30) @(posedge clk); #1;
    check_state("glitch");
    peek(A_RXD, d); check("glitch_rxd", d, {24'b0, m_data});

    // Framing error leaves a pending byte untouched
    rb = 8'($urandom);
    send_frame(rb, 1'b1); model_rx(rb, 1'b1);
    send_frame(8'($urandom), 1'b0); model_rx(8'h00, 1'b0);
    repeat (12) @(posedge clk); #1;
    check_state("ferr");
    peek(A_RXD, d); check("ferr_rxd", d, {24'b0, rb});
    exp_w = exp_con();
    bus_read(A_CON, d); check("ferr_con_read", d, exp_w);
    bus_read(A_RXD, d);
    check_state("ferr_clr");

    // Overrun: two frames without a read
    send_frame(8'h11, 1'b1); model_rx(8'h11, 1'b1);
    send_frame(8'h22, 1'b1); model_rx(8'h22, 1'b1);
    check_state("overrun");
    peek(A_RXD, d); check("overrun_rxd", d, 32'h22);
    exp_w = exp_con();
    bus_read(A_CON, d); check("overrun_con_read", d, exp_w);
    bus_read(A_RXD, d);
    check_state("overrun_clr");

    // Reset in the middle of DATA bit 3
    bus_write(A_CON, 32'h3);
    bus_write(A_TXD, {24'b0, 8'($urandom)});
    repeat (70) @(posedge clk); #1;
    reset = 1; @(posedge clk); #1 reset = 0;
    model_reset();
    check("midrst_tx", {31'b0, uart_tx}, 1);
    check_state("midrst");
    peek(A_RXD, d); check("midrst_rxd", d, 0);
    saw_low = 0;
    for (int i = 0; i < 200; i++) begin @(posedge clk); #1; if (uart_tx !== 1'b1) saw_low = 1; end
    check("midrst_line_idle", {31'b0, saw_low}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
